// File: rtl/param_register_file.sv
// Parametrised register file: two combinational read ports (port 2 can be forced to R0),
// double-word writes into R0 plus write_address, optional write bypass and a sequenced bulk clear.
module param_register_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt_sys,
  input  logic                  R0_read,
  input  logic [ADDR_W-1:0]     ra1,
  input  logic [ADDR_W-1:0]     ra2,
  input  logic                  write_en,
  input  logic                  R0_en,
  input  logic [ADDR_W-1:0]     write_address,
  input  logic [2*DATA_W-1:0]   write_data,
  input  logic                  clr_req,
  output logic [DATA_W-1:0]     rd1,
  output logic [DATA_W-1:0]     rd2,
  output logic                  clr_busy,
  output logic                  wr_dropped
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [DATA_W-1:0]   wd_hi, wd_lo;
  logic [ADDR_W-1:0]   ra2_sel;
  logic                clr_start, clr_step, wr_eff, drop_nxt;

  assign wd_hi   = write_data[2*DATA_W-1:DATA_W];
  assign wd_lo   = write_data[DATA_W-1:0];
  assign ra2_sel = R0_read ? '0 : ra2;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    clr_start = 1'b0;
    clr_step  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req && !halt_sys) begin
          clr_start = 1'b1;
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        if (!halt_sys) begin
          clr_step = 1'b1;
          if (ptr == ADDR_W'(DEPTH-1)) begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
          end else begin
            ptr_nxt = ptr + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A starting clear takes priority over a write arriving in the same cycle.
  assign wr_eff   = write_en && !halt_sys && (state == IDLE) && !clr_start;
  assign drop_nxt = write_en && !halt_sys && ((state == CLEAR) || clr_start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      wr_dropped <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      wr_dropped <= drop_nxt;
    end
  end

  // Low word is written after the high word so it wins when write_address is R0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (clr_step) regs[ptr] <= '0;
      if (wr_eff) begin
        if (R0_en) regs[0] <= wd_hi;
        regs[write_address] <= wd_lo;
      end
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2_sel];
    if ((BYPASS != 0) && wr_eff) begin
      if (ra1 == write_address)       rd1 = wd_lo;
      else if (R0_en && ra1 == '0)    rd1 = wd_hi;
      if (ra2_sel == write_address)   rd2 = wd_lo;
      else if (R0_en && ra2_sel == '0) rd2 = wd_hi;
    end
  end

  assign clr_busy = (state == CLEAR);

endmodule

// File: tb/tb_param_register_file.sv
// Randomised bench for param_register_file: BYPASS=1 and BYPASS=0 instances share stimulus
// and are compared against an array-based reference model of the register file.
module tb_param_register_file;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_sys, r0_read, write_en, r0_en, clr_req;
  logic [3:0]  ra1, ra2, wa;
  logic [31:0] wd;
  logic [15:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;
  logic        busy_b1, busy_b0, drop_b1, drop_b0;

  int          checks = 0;
  int          errors = 0;

  logic [15:0] mdl [DEPTH];
  int          clr_left;
  bit          m_drop;

  always #5 clk = ~clk;

  param_register_file #(.DATA_W(16), .ADDR_W(4), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .R0_read(r0_read),
    .ra1(ra1), .ra2(ra2), .write_en(write_en), .R0_en(r0_en),
    .write_address(wa), .write_data(wd), .clr_req(clr_req),
    .rd1(rd1_b1), .rd2(rd2_b1), .clr_busy(busy_b1), .wr_dropped(drop_b1)
  );

  param_register_file #(.DATA_W(16), .ADDR_W(4), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .R0_read(r0_read),
    .ra1(ra1), .ra2(ra2), .write_en(write_en), .R0_en(r0_en),
    .write_address(wa), .write_data(wd), .clr_req(clr_req),
    .rd1(rd1_b0), .rd2(rd2_b0), .clr_busy(busy_b0), .wr_dropped(drop_b0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write accepted this cycle: idle, not halted, and no clear starting now.
  function automatic bit write_taken();
    bit busy = (clr_left > 0);
    bit start = !busy && clr_req && !halt_sys;
    return write_en && !halt_sys && !busy && !start;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [3:0] a, input bit byp);
    if (byp && write_taken() && a == wa) return wd[15:0];
    if (byp && write_taken() && r0_en && a == 4'd0) return wd[31:16];
    return mdl[a];
  endfunction

  task automatic set_idle();
    halt_sys = 0; r0_read = 0; write_en = 0; r0_en = 0; clr_req = 0;
    ra1 = 0; ra2 = 0; wa = 0; wd = 0;
  endtask

  // Called at a negedge with inputs set; checks outputs, then advances the model one clock.
  task automatic cycle();
    logic [3:0] a2;
    bit busy, start, eff, nxt_drop;
    #1;
    a2 = r0_read ? 4'd0 : ra2;
    check("rd1_byp1", rd1_b1, exp_rd(ra1, 1));
    check("rd2_byp1", rd2_b1, exp_rd(a2, 1));
    check("rd1_byp0", rd1_b0, exp_rd(ra1, 0));
    check("rd2_byp0", rd2_b0, exp_rd(a2, 0));
    check("clr_busy", {busy_b1, busy_b0}, {2{clr_left > 0}});
    check("wr_dropped", {drop_b1, drop_b0}, {2{m_drop}});
    @(posedge clk);
    busy     = (clr_left > 0);
    start    = !busy && clr_req && !halt_sys;
    eff      = write_taken();
    nxt_drop = write_en && !halt_sys && (busy || start);
    if (busy && !halt_sys) begin
      mdl[DEPTH - clr_left] = '0;
      clr_left--;
    end else if (start) begin
      clr_left = DEPTH;
    end
    if (eff) begin
      if (r0_en) mdl[0] = wd[31:16];
      mdl[wa] = wd[15:0];
    end
    m_drop = nxt_drop;
    @(negedge clk);
  endtask

  // Asserted mid-cycle: outputs must clear at once, without waiting for a clock edge.
  task automatic reset_dut();
    set_idle();
    rst = 1;
    #1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    clr_left = 0;
    m_drop   = 0;
    check("rst_busy", {busy_b1, busy_b0}, 2'b00);
    check("rst_drop", {drop_b1, drop_b0}, 2'b00);
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = 4'(i);
      ra2 = 4'(DEPTH - 1 - i);
      #1;
      check("rst_regs", {rd1_b1, rd2_b0}, 32'h0);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d, input bit r0);
    set_idle();
    write_en = 1; wa = a; wd = d; r0_en = r0;
    cycle();
    set_idle();
  endtask

  // Runs a clear already requested; counts busy cycles, optionally writing in busy cycle drop_at.
  task automatic measure_clear(input int drop_at, output int n);
    bit prev_wr = 0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (prev_wr) check("clr_drop_pulse", drop_b1, 1'b1);
      if (busy_b1) n++;
      write_en = busy_b1 && (n == drop_at);
      wa = 4'd9;
      wd = $urandom;
      prev_wr = write_en;
      cycle();
    end
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    set_idle();
    rst = 1;
    @(negedge clk);
    reset_dut();

    // Plain low-word write, then read back with R0 untouched
    write_reg(4'd5, 32'h0000_ABCD, 0);
    ra1 = 4'd5; r0_read = 1;
    #1;
    check("t1_rd1", rd1_b1, 16'hABCD);
    check("t1_r0", rd2_b1, 16'h0000);
    cycle();

    // Double-word write: high word to R0, low word to address 3, then address 0 collision
    write_reg(4'd3, 32'h1234_5678, 1);
    ra1 = 4'd3; r0_read = 1;
    #1;
    check("t2_rd2_r0", rd2_b0, 16'h1234);
    check("t2_rd1", rd1_b0, 16'h5678);
    cycle();
    write_reg(4'd0, 32'h1234_5678, 1);
    r0_read = 1; ra2 = 4'd6;
    #1;
    check("t2_r0_low_wins", rd2_b0, 16'h5678);
    cycle();

    // Bypass versus flop contents
    write_reg(4'd7, 32'h0000_1111, 0);
    write_en = 1; wa = 4'd7; wd = 32'h0000_BEEF; ra1 = 4'd7;
    #1;
    check("t3_bypass1", rd1_b1, 16'hBEEF);
    check("t3_bypass0", rd1_b0, 16'h1111);
    cycle();
    set_idle();

    // Halted write is not taken and not a drop
    write_reg(4'd2, 32'h0000_AAAA, 0);
    halt_sys = 1; write_en = 1; wa = 4'd2; wd = 32'h0000_5555; ra1 = 4'd2;
    cycle();
    set_idle();
    ra1 = 4'd2;
    #1;
    check("t4_held", rd1_b0, 16'hAAAA);
    check("t4_no_drop", drop_b1, 1'b0);
    cycle();
    write_reg(4'd2, 32'h0000_5555, 0);
    ra1 = 4'd2;
    #1;
    check("t4_lands", rd1_b0, 16'h5555);
    cycle();

    // Fill, clear with a write in busy cycle 4, then everything reads zero
    for (int i = 0; i < DEPTH; i++) write_reg(4'(i), $urandom | 32'h1, 0);
    clr_req = 1;
    cycle();
    clr_req = 0;
    measure_clear(4, n);
    check("t5_busy_cycles", n, 16);
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = 4'(i); ra2 = 4'(i);
      #1;
      check("t5_cleared", rd1_b0, 16'h0);
      cycle();
    end

    // Reset in clear cycle 6, then a fresh full clear
    for (int i = 0; i < DEPTH; i++) write_reg(4'(i), $urandom | 32'h1, 1);
    clr_req = 1;
    cycle();
    clr_req = 0;
    repeat (5) cycle();
    reset_dut();
    for (int i = 0; i < 4; i++) write_reg(4'(i + 8), $urandom, 0);
    clr_req = 1;
    cycle();
    clr_req = 0;
    measure_clear(0, n);
    check("t6_busy_cycles", n, 16);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      write_en = ($urandom % 2) == 0;
      r0_en    = ($urandom % 3) == 0;
      r0_read  = ($urandom % 4) == 0;
      halt_sys = ($urandom % 8) == 0;
      clr_req  = ($urandom % 25) == 0;
      ra1      = 4'($urandom);
      ra2      = 4'($urandom);
      wa       = 4'($urandom);
      wd       = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
